// File: rtl/sample_tx_sched.sv
// sample_tx_sched: round-robin scheduler that shares one UART byte serializer
// among NCH 12-bit sample sources. Each grant is sent as an ASCII frame
// "<ch><hex><hex><hex>\r\n". Also produces the baud-rate strobe.
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | no frame in flight; arbitrate among req when en=1
// SEND      | tx_start pulse; tx_byte valid for the serializer
// WAIT_ACC  | waiting for tx_busy to rise (timeout means accepted+done)
// WAIT_DONE | serializer busy; wait for tx_busy to fall
// NEXT      | advance byte index, or finish the frame after LF
module sample_tx_sched #(
    parameter int NCH         = 4,
    parameter int BAUD_DIV    = 104,
    parameter int ACC_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [NCH-1:0]    req,
    input  logic [12*NCH-1:0] data_flat,
    output logic [NCH-1:0]    ack,
    output logic [2:0]        grant_ch,
    output logic              busy,
    output logic              baud_tick,
    output logic [7:0]        tx_byte,
    output logic              tx_start,
    input  logic              tx_busy
);

    localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int TW = $clog2(ACC_TIMEOUT + 1);
    localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
    localparam logic [TW-1:0] TMR_LOAD  = TW'(ACC_TIMEOUT - 1);
    localparam logic [2:0]    LAST_INIT = 3'(NCH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_WAIT_ACC,
        S_WAIT_DONE,
        S_NEXT
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [TW-1:0]  tmr_q, tmr_d;
    logic [2:0]     idx_q, idx_d;
    logic [2:0]     last_q, last_d;
    logic [2:0]     grant_q, grant_d;
    logic [11:0]    sample_q, sample_d;
    logic [7:0]     tx_byte_q, tx_byte_d;
    logic           busy_q, busy_d;

    logic           hi_found, lo_found, win_found, grant_ok;
    logic [2:0]     hi_idx, lo_idx, win_idx;
    logic [11:0]    win_data;

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    function automatic logic [7:0] frame_byte(input logic [2:0] idx,
                                              input logic [2:0] ch,
                                              input logic [11:0] smp);
        case (idx)
            3'd0:    return 8'h30 + {5'b0, ch};
            3'd1:    return hex_ascii(smp[11:8]);
            3'd2:    return hex_ascii(smp[7:4]);
            3'd3:    return hex_ascii(smp[3:0]);
            3'd4:    return 8'h0D;
            default: return 8'h0A;
        endcase
    endfunction

    // Rotating priority: lowest requester above last wins, else lowest at/below last.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (req[i]) begin
                if (i > int'(last_q)) begin
                    hi_found = 1'b1;
                    hi_idx   = 3'(i);
                end else begin
                    lo_found = 1'b1;
                    lo_idx   = 3'(i);
                end
            end
        end
        win_found = hi_found | lo_found;
        win_idx   = hi_found ? hi_idx : lo_idx;
        win_data  = '0;
        for (int i = 0; i < NCH; i++) begin
            if (win_idx == 3'(i)) win_data = data_flat[12*i +: 12];
        end
        grant_ok = rst_n && en && (state_q == S_IDLE) && win_found;
    end

    // Outputs decoded straight from state so reset silences them in the same cycle.
    always_comb begin
        ack = '0;
        for (int i = 0; i < NCH; i++) begin
            ack[i] = grant_ok && (win_idx == 3'(i));
        end
        tx_start  = rst_n && (state_q == S_SEND);
        baud_tick = rst_n && en && (cnt_q == BAUD_LAST);
        tx_byte   = tx_byte_q;
        busy      = busy_q;
        grant_ch  = grant_q;
    end

    // Next-state computation for the baud counter and the frame sequencer.
    always_comb begin
        cnt_d     = en ? ((cnt_q == BAUD_LAST) ? '0 : cnt_q + 1'b1) : '0;
        state_d   = state_q;
        tmr_d     = tmr_q;
        idx_d     = idx_q;
        last_d    = last_q;
        grant_d   = grant_q;
        sample_d  = sample_q;
        tx_byte_d = tx_byte_q;
        busy_d    = busy_q;
        case (state_q)
            S_IDLE: begin
                if (grant_ok) begin
                    sample_d  = win_data;
                    grant_d   = win_idx;
                    last_d    = win_idx;
                    busy_d    = 1'b1;
                    idx_d     = 3'd0;
                    tx_byte_d = frame_byte(3'd0, win_idx, win_data);
                    state_d   = S_SEND;
                end
            end
            S_SEND: begin
                tmr_d   = TMR_LOAD;
                state_d = S_WAIT_ACC;
            end
            S_WAIT_ACC: begin
                if (tx_busy) begin
                    state_d = S_WAIT_DONE;
                end else if (tmr_q == '0) begin
                    state_d = S_NEXT;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            S_WAIT_DONE: begin
                if (!tx_busy) state_d = S_NEXT;
            end
            S_NEXT: begin
                if (idx_q == 3'd5) begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    idx_d     = idx_q + 3'd1;
                    tx_byte_d = frame_byte(idx_q + 3'd1, grant_q, sample_q);
                    state_d   = S_SEND;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            tmr_q     <= '0;
            idx_q     <= '0;
            last_q    <= LAST_INIT;
            grant_q   <= '0;
            sample_q  <= '0;
            tx_byte_q <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tmr_q     <= tmr_d;
            idx_q     <= idx_d;
            last_q    <= last_d;
            grant_q   <= grant_d;
            sample_q  <= sample_d;
            tx_byte_q <= tx_byte_d;
            busy_q    <= busy_d;
        end
    end

endmodule

// File: tb/tb_sample_tx_sched.sv
// Directed bench for sample_tx_sched (NCH=4, BAUD_DIV=104, ACC_TIMEOUT=16).
module tb_sample_tx_sched;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [3:0]  req = '0;
    logic [47:0] data_flat;
    logic [3:0]  ack;
    logic [2:0]  grant_ch;
    logic        busy, baud_tick, tx_start;
    logic [7:0]  tx_byte;
    logic        tx_busy = 1'b0;

    logic [11:0] dat [4];
    assign data_flat = {dat[3], dat[2], dat[1], dat[0]};

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    bit model_on = 1'b0;
    int bticks = 0;

    logic [7:0] byte_q[$];
    logic [3:0] ack_q[$];
    int         ack_cyc[$];
    int         start_cyc[$];

    sample_tx_sched #(.NCH(4), .BAUD_DIV(104), .ACC_TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .req(req), .data_flat(data_flat),
        .ack(ack), .grant_ch(grant_ch), .busy(busy), .baud_tick(baud_tick),
        .tx_byte(tx_byte), .tx_start(tx_start), .tx_busy(tx_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Serializer model: busy for 10 baud ticks after each accepted byte.
    always @(negedge clk) begin
        if (!model_on || !rst_n) begin
            tx_busy = 1'b0;
            bticks  = 0;
        end else if (!tx_busy) begin
            if (tx_start) begin
                tx_busy = 1'b1;
                bticks  = 0;
            end
        end else begin
            if (baud_tick) bticks++;
            if (bticks == 10) tx_busy = 1'b0;
        end
    end

    // Transaction monitor.
    always @(negedge clk) begin
        if (tx_start) begin
            byte_q.push_back(tx_byte);
            start_cyc.push_back(cyc);
        end
        if (ack != '0) begin
            ack_q.push_back(ack);
            ack_cyc.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        byte_q.delete();
        ack_q.delete();
        ack_cyc.delete();
        start_cyc.delete();
    endtask

    task automatic do_reset(input logic en_v);
        @(posedge clk); #1;
        rst_n = 1'b0;
        en    = en_v;
        req   = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_mon();
    endtask

    task automatic wait_ack(input string tag, input int lim);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ack == '0 && n < lim);
        chk({tag, "_seen"}, 32'(ack != '0), 1);
    endtask

    task automatic wait_busy_low(input string tag, input int lim);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < lim);
        chk(tag, 32'(busy), 0);
    endtask

    task automatic wait_starts(input string tag, input int cnt, input int lim);
        int n, seen;
        n = 0;
        seen = 0;
        while (seen < cnt && n < lim) begin
            @(negedge clk);
            n++;
            if (tx_start) seen++;
        end
        chk(tag, seen, cnt);
    endtask

    logic [7:0] exp1 [6] = '{8'h30, 8'h41, 8'h35, 8'h43, 8'h0D, 8'h0A};
    logic [7:0] exp_ch1 [6] = '{8'h31, 8'h30, 8'h46, 8'h33, 8'h0D, 8'h0A};
    logic [3:0] exp_rr [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};

    initial begin
        int ticks[$];
        int n, first;
        dat[0] = 12'hA5C; dat[1] = 12'h0F3; dat[2] = 12'hB07; dat[3] = 12'hFFF;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ack", 32'(ack), 0);
        chk("rst_tx_start", 32'(tx_start), 0);
        chk("rst_tx_byte", 32'(tx_byte), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_grant", 32'(grant_ch), 0);
        chk("rst_baud", 32'(baud_tick), 0);

        // Baud tick cadence and en gating
        do_reset(1'b1);
        for (int c = 1; c <= 320; c++) begin
            @(negedge clk);
            if (baud_tick) ticks.push_back(c);
            @(posedge clk);
        end
        #1;
        chk("baud_cnt", ticks.size(), 3);
        if (ticks.size() >= 3) begin
            chk("baud_t0", ticks[0], 104);
            chk("baud_t1", ticks[1], 208);
            chk("baud_t2", ticks[2], 312);
        end
        en = 1'b0;
        n = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (baud_tick) n++;
            @(posedge clk);
        end
        #1;
        chk("baud_en0", n, 0);
        en = 1'b1;
        first = 0;
        for (int c = 1; c <= 110; c++) begin
            @(negedge clk);
            if (baud_tick && first == 0) first = c;
            @(posedge clk);
        end
        chk("baud_restart", first, 104);

        // Single frame through the serializer model
        do_reset(1'b1);
        model_on = 1'b1;
        req = 4'b0001;
        wait_ack("f1_ack", 20);
        chk("f1_ack_val", 32'(ack), 32'h1);
        @(posedge clk); #1;
        req = 4'b0000;
        dat[0] = 12'h000;
        @(negedge clk);
        chk("f1_start_t1", 32'(tx_start), 1);
        chk("f1_busy", 32'(busy), 1);
        chk("f1_grant", 32'(grant_ch), 0);
        wait_busy_low("f1_busy_fall", 9000);
        chk("f1_nbytes", byte_q.size(), 6);
        for (int i = 0; i < 6; i++)
            if (i < byte_q.size()) chk($sformatf("f1_byte%0d", i), 32'(byte_q[i]), 32'(exp1[i]));
        chk("f1_nack", ack_q.size(), 1);
        chk("f1_txbusy_done", 32'(tx_busy), 0);
        model_on = 1'b0;
        dat[0] = 12'hA5C;

        // Round robin, all requests held, serializer never answers
        do_reset(1'b1);
        req = 4'b1111;
        n = 0;
        while (ack_q.size() < 6 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk); #1;
        req = 4'b0000;
        wait_busy_low("rr_busy_fall", 300);
        chk("rr_nack", ack_q.size(), 6);
        for (int i = 0; i < 6; i++)
            if (i < ack_q.size()) chk($sformatf("rr_ack%0d", i), 32'(ack_q[i]), 32'(exp_rr[i]));
        chk("rr_nbytes", byte_q.size(), 36);
        if (ack_cyc.size() >= 2 && start_cyc.size() >= 6) begin
            chk("rr_ack_to_start", start_cyc[0] - ack_cyc[0], 1);
            chk("rr_timeout_gap", start_cyc[1] - start_cyc[0], 18);
            chk("rr_last_gap", start_cyc[5] - start_cyc[4], 18);
            chk("rr_frame_gap", ack_cyc[1] - ack_cyc[0], 109);
        end
        for (int i = 0; i < 6; i++)
            if (i + 6 < byte_q.size()) chk($sformatf("rr_ch1_byte%0d", i), 32'(byte_q[i+6]), 32'(exp_ch1[i]));

        // en dropped mid-frame with another channel pending
        do_reset(1'b1);
        dat[0] = 12'h123;
        req = 4'b0001;
        wait_ack("en_ack0", 20);
        chk("en_ack0_val", 32'(ack), 32'h1);
        @(posedge clk); #1;
        req = 4'b0010;
        wait_starts("en_starts", 3, 100);
        @(posedge clk); #1;
        en = 1'b0;
        wait_busy_low("en_busy_fall", 200);
        repeat (30) @(negedge clk);
        chk("en_nbytes", byte_q.size(), 6);
        if (byte_q.size() == 6) begin
            chk("en_byte3", 32'(byte_q[3]), 32'h33);
            chk("en_last_lf", 32'(byte_q[5]), 32'h0A);
        end
        chk("en_no_ack", ack_q.size(), 1);
        @(posedge clk); #1;
        en = 1'b1;
        wait_ack("en_ack1", 20);
        chk("en_ack1_val", 32'(ack), 32'h2);
        @(posedge clk); #1;
        req = 4'b0000;
        wait_busy_low("en_busy_fall2", 200);

        // Reset during byte 3
        do_reset(1'b1);
        dat[0] = 12'h7E1;
        req = 4'b0001;
        wait_ack("rs_ack0", 20);
        @(posedge clk); #1;
        req = 4'b0000;
        wait_starts("rs_starts", 3, 100);
        repeat (18) @(posedge clk);
        #1;
        rst_n = 1'b0;
        req = 4'b1010;
        @(negedge clk);
        chk("rs_start_forced", 32'(tx_start), 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rs_busy", 32'(busy), 0);
        chk("rs_tx_start", 32'(tx_start), 0);
        chk("rs_tx_byte", 32'(tx_byte), 0);
        chk("rs_ack", 32'(ack), 0);
        chk("rs_nstarts", start_cyc.size(), 3);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rs_first_grant", 32'(ack), 32'h2);
        @(posedge clk); #1;
        req = 4'b0000;
        @(negedge clk);
        chk("rs_grant_ch", 32'(grant_ch), 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
